// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: access-width codes and byte-lane enable helper for the MEM stage
package mips_mem_pkg;
    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_WORD = 2'b10,
        W_ILL  = 2'b11
    } width_e;

    localparam int NB_BE_MAX = 16;

    function automatic logic [NB_BE_MAX-1:0] lane_be(input width_e w, input logic [3:0] lane, input int unsigned nl);
        return w == W_BYTE ? 16'h1 << lane :
               w == W_HALF ? 16'h3 << lane :
               w == W_WORD ? 16'((32'h1 << nl) - 32'h1) : '0;
    endfunction
endpackage

// File: rtl/data_ram_be.sv
// data_ram_be: single-port byte-enable RAM with registered, enable-gated read
module data_ram_be #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
) (
    input  logic                                   clk,
    input  logic                                   i_rst_n,
    input  logic [NB_DATA/8-1:0]                   i_we,
    input  logic                                   i_re,
    input  logic [NB_ADDR-$clog2(NB_DATA/8)-1:0]   i_addr,
    input  logic [NB_DATA-1:0]                     i_wdata,
    output logic [NB_DATA-1:0]                     o_rdata
);
    localparam int NB_LANE = NB_DATA / 8;
    localparam int DEPTH   = 2 ** (NB_ADDR - $clog2(NB_LANE));

    logic [NB_DATA-1:0] mem [DEPTH];
    logic [NB_DATA-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB_LANE; i++)
            if (i_we[i]) mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
    end

    always_comb begin
        rdata_d = i_re ? mem[i_addr] : rdata_q;
        o_rdata = rdata_q;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end
endmodule

// File: rtl/memory_access_be.sv
// memory_access_be: MIPS MEM stage with lane-select loads, fault detect, MEM/WB register and halt debug read
module memory_access_be
    import mips_mem_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10,
    parameter int NB_REG  = 5
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_halt,
    input  logic               i_flush,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [NB_REG-1:0]  i_reg2write,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_mem2reg,
    input  logic               i_regWrite,
    input  logic               i_dbg_re,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_reg_read,
    output logic [NB_DATA-1:0] o_ALUresult,
    output logic [NB_REG-1:0]  o_reg2write,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic               o_mem_fault,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic               o_dbg_valid
);
    localparam int NB_LANE = NB_DATA / 8;
    localparam int LB      = $clog2(NB_LANE);

    logic [NB_ADDR-1:0]    addr;
    logic [LB-1:0]         lane;
    logic                  fault, adv, dbg_rd, wr_en, unused_ok;
    logic [NB_BE_MAX-1:0]  be_full;
    logic [NB_LANE-1:0]    ram_we;
    logic [NB_ADDR-LB-1:0] ram_addr;
    logic [NB_DATA-1:0]    ram_wdata, ram_rdata, ld_word;
    logic [15:0]           ld_half;

    logic [NB_DATA-1:0] alu_d, alu_q, shadow_d, shadow_q;
    logic [NB_REG-1:0]  reg2write_d, reg2write_q;
    logic [LB-1:0]      lane_d, lane_q;
    width_e             width_d, width_q;
    logic mem2reg_d, mem2reg_q, regwrite_d, regwrite_q, mem_fault_d, mem_fault_q;
    logic sign_d, sign_q, kill_d, kill_q, dbg_valid_d, dbg_valid_q, shadow_v_d, shadow_v_q;

    data_ram_be #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_ram (
        .clk    (clk),
        .i_rst_n(i_rst_n),
        .i_we   (ram_we),
        .i_re   (adv | dbg_rd),
        .i_addr (ram_addr),
        .i_wdata(ram_wdata),
        .o_rdata(ram_rdata)
    );

    assign unused_ok = ^{i_result[NB_DATA-1:NB_ADDR], i_dbg_addr[LB-1:0], be_full[NB_BE_MAX-1:NB_LANE]};

    always_comb begin
        addr        = i_result[NB_ADDR-1:0];
        lane        = addr[LB-1:0];
        fault       = (i_memRead | i_memWrite) &
                      (i_width == W_ILL | (i_width == W_HALF & addr[0]) | (i_width == W_WORD & lane != '0));
        adv         = i_flush | ~(i_stall | i_halt);
        dbg_rd      = i_halt & i_dbg_re & ~adv;
        wr_en       = i_rst_n & i_memWrite & ~fault & ~i_stall & ~i_halt & ~i_flush;
        be_full     = lane_be(width_e'(i_width), 4'(lane), NB_LANE);
        ram_we      = be_full[NB_LANE-1:0] & {NB_LANE{wr_en}};
        ram_wdata   = i_width == W_BYTE ? {NB_LANE{i_data4Mem[7:0]}} :
                      i_width == W_HALF ? {(NB_LANE/2){i_data4Mem[15:0]}} : i_data4Mem;
        ram_addr    = adv ? addr[NB_ADDR-1:LB] : i_dbg_addr[NB_ADDR-1:LB];
        alu_d       = alu_q;
        reg2write_d = reg2write_q;
        mem2reg_d   = mem2reg_q;
        regwrite_d  = regwrite_q;
        mem_fault_d = 1'b0;
        lane_d      = lane_q;
        width_d     = width_q;
        sign_d      = sign_q;
        kill_d      = kill_q;
        shadow_d    = shadow_q;
        shadow_v_d  = shadow_v_q;
        dbg_valid_d = dbg_rd;
        if (adv) begin
            alu_d       = i_result;
            reg2write_d = i_reg2write;
            mem2reg_d   = i_mem2reg & ~i_flush;
            regwrite_d  = i_regWrite & ~fault & ~i_flush;
            mem_fault_d = fault & ~i_flush;
            lane_d      = lane;
            width_d     = width_e'(i_width);
            sign_d      = i_sign_flag;
            kill_d      = fault;
            shadow_v_d  = 1'b0;
        end else if (dbg_rd && !shadow_v_q) begin
            // the debug read overwrites the RAM output register, so keep the held load word aside
            shadow_d   = ram_rdata;
            shadow_v_d = 1'b1;
        end
        ld_word     = shadow_v_q ? shadow_q : ram_rdata;
        ld_half     = 16'(ld_word >> {lane_q, 3'b000});
        o_reg_read  = kill_q ? '0 :
                      width_q == W_BYTE ? {{(NB_DATA-8){sign_q & ld_half[7]}}, ld_half[7:0]} :
                      width_q == W_HALF ? {{(NB_DATA-16){sign_q & ld_half[15]}}, ld_half} : ld_word;
        o_ALUresult = alu_q;
        o_reg2write = reg2write_q;
        o_mem2reg   = mem2reg_q;
        o_regWrite  = regwrite_q;
        o_mem_fault = mem_fault_q;
        o_dbg_data  = ram_rdata;
        o_dbg_valid = dbg_valid_q;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            alu_q       <= '0;
            reg2write_q <= '0;
            mem2reg_q   <= 1'b0;
            regwrite_q  <= 1'b0;
            mem_fault_q <= 1'b0;
            lane_q      <= '0;
            width_q     <= W_BYTE;
            sign_q      <= 1'b0;
            kill_q      <= 1'b0;
            shadow_q    <= '0;
            shadow_v_q  <= 1'b0;
            dbg_valid_q <= 1'b0;
        end else begin
            alu_q       <= alu_d;
            reg2write_q <= reg2write_d;
            mem2reg_q   <= mem2reg_d;
            regwrite_q  <= regwrite_d;
            mem_fault_q <= mem_fault_d;
            lane_q      <= lane_d;
            width_q     <= width_d;
            sign_q      <= sign_d;
            kill_q      <= kill_d;
            shadow_q    <= shadow_d;
            shadow_v_q  <= shadow_v_d;
            dbg_valid_q <= dbg_valid_d;
        end
    end
endmodule
